// File: rtl/arbitro_rr_vc_if.sv
// Bus bundle between the VC input FIFOs, the arbiter and the destination FIFOs.
// master = FIFO side (drives flags and head words), slave = arbiter.
interface arbitro_rr_vc_if #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned NUM_VC = 4
);
  logic [NUM_VC-1:0]        FIFO_empty;
  logic [NUM_VC*DATA_W-1:0] dato_in;
  logic [NUM_VC-1:0]        almost_full;
  logic [NUM_VC-1:0]        pop;
  logic [NUM_VC-1:0]        push;
  logic [DATA_W-1:0]        dato_out;

  modport master (
    output FIFO_empty, dato_in, almost_full,
    input  pop, push, dato_out
  );

  modport slave (
    input  FIFO_empty, dato_in, almost_full,
    output pop, push, dato_out
  );
endinterface

// File: rtl/arbitro_rr_vc.sv
// Round-robin arbiter from 4 VC input FIFOs to 4 destination FIFOs.
// One word per cycle: pop (combinational) in cycle t, push/dato_out registered in t+1.
// Optional build macro ARB_STRICT_PRIO_EN: fixed priority VC0 > VC1 > VC2 > VC3
// (pointer held at 0); default build is round-robin.
module arbitro_rr_vc #(
  parameter int unsigned DATA_W = 6,
  parameter int unsigned NUM_VC = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  arbitro_rr_vc_if.slave        bus,
  output logic [1:0]            estado
);

  localparam int unsigned PTR_W  = 2;
  localparam int unsigned DEST_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACTIVE = 2'b01,
    STALL  = 2'b10
  } state_t;

  state_t              state;
  logic [PTR_W-1:0]    ptr;
  logic [NUM_VC-1:0]   push_q;
  logic [DATA_W-1:0]   dato_q;

  logic [NUM_VC-1:0]   req;
  logic                any_req;
  logic                bloqueo;
  logic                gnt_vld;
  logic [PTR_W-1:0]    gnt_idx;
  logic [DATA_W-1:0]   head;
  logic [DEST_W-1:0]   dest;

  assign req     = ~bus.FIFO_empty;
  assign any_req = |req;
  // Any almost-full destination stalls every VC, so words are never reordered.
  assign bloqueo = |bus.almost_full;

  // Search from the pointer for the first requester; lowest offset wins.
  always_comb begin
    logic [PTR_W-1:0] cand;
    cand    = '0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    if (!reset && !init && !bloqueo) begin
      for (int k = int'(NUM_VC) - 1; k >= 0; k--) begin
        cand = ptr + PTR_W'(k);
        if (req[cand]) begin
          gnt_vld = 1'b1;
          gnt_idx = cand;
        end
      end
    end
  end

  assign head    = bus.dato_in[int'(gnt_idx)*DATA_W +: DATA_W];
  assign dest    = head[DATA_W-1 -: DEST_W];
  assign bus.pop = gnt_vld ? (NUM_VC'(1) << gnt_idx) : '0;

  assign bus.push     = push_q;
  assign bus.dato_out = dato_q;
  assign estado       = state;

  // Register the granted word and its destination strobe; advance the pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr    <= '0;
      push_q <= '0;
      dato_q <= '0;
    end else if (gnt_vld) begin
`ifdef ARB_STRICT_PRIO_EN
      ptr    <= '0;
`else
      ptr    <= gnt_idx + PTR_W'(1);
`endif
      dato_q <= head;
      push_q <= NUM_VC'(1) << dest;
    end else begin
      push_q <= '0;
    end
  end

  // Status FSM; it does not gate pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else if (init || !any_req) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    state <= bloqueo ? STALL : ACTIVE;
        ACTIVE:  state <= bloqueo ? STALL : ACTIVE;
        STALL:   state <= bloqueo ? STALL : ACTIVE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_rr_vc.sv
// Bench for arbitro_rr_vc: directed scenarios then random traffic, all checked
// against a cycle-level reference model of the arbitration rules.
module tb_arbitro_rr_vc;

  logic       clk;
  logic       reset;
  logic       init;
  logic [1:0] estado;

  arbitro_rr_vc_if #(.DATA_W(6), .NUM_VC(4)) bus ();

  arbitro_rr_vc #(.DATA_W(6), .NUM_VC(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .init   (init),
    .bus    (bus),
    .estado (estado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state (values the registered outputs must show after the edge)
  int         m_ptr;
  logic [3:0] m_push;
  logic [5:0] m_dout;
  int         m_st;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, check pop, model the edge, then check registered outputs.
  task automatic step(input logic rst, input logic ini, input logic [3:0] emp,
                      input logic [23:0] din, input logic [3:0] af);
    int         g;
    logic [3:0] exp_pop;
    logic [5:0] word;
    reset           = rst;
    init            = ini;
    bus.FIFO_empty  = emp;
    bus.dato_in     = din;
    bus.almost_full = af;
    #1;
    g       = -1;
    exp_pop = 4'b0000;
    if (!rst && !ini && af == 4'b0000) begin
      for (int k = 0; k < 4; k++) begin
        int v;
        v = (m_ptr + k) % 4;
        if (!emp[v] && g < 0) g = v;
      end
    end
    if (g >= 0) exp_pop = 4'(1 << g);
    chk("pop", 32'(bus.pop), 32'(exp_pop));

    if (rst) begin
      m_ptr  = 0;
      m_push = 4'b0000;
      m_dout = 6'h00;
      m_st   = 0;
    end else begin
      if (g >= 0) begin
        word   = din[g*6 +: 6];
        m_dout = word;
        m_push = 4'(1 << word[5:4]);
`ifdef ARB_STRICT_PRIO_EN
        m_ptr  = 0;
`else
        m_ptr  = (g + 1) % 4;
`endif
      end else begin
        m_push = 4'b0000;
      end
      if (ini || emp == 4'b1111) m_st = 0;
      else if (af != 4'b0000)    m_st = 2;
      else                       m_st = 1;
    end

    @(posedge clk);
    #1;
    chk("push",     32'(bus.push),     32'(m_push));
    chk("dato_out", 32'(bus.dato_out), 32'(m_dout));
    chk("estado",   32'(estado),       32'(m_st));
  endtask

  localparam logic [23:0] HEADS = {6'h30, 6'h23, 6'h12, 6'h05};

  initial begin
    m_ptr  = 0;
    m_push = 4'b0000;
    m_dout = 6'h00;
    m_st   = 0;

    // Reset for two cycles with all FIFOs empty
    repeat (2) step(1'b1, 1'b0, 4'b1111, HEADS, 4'b0000);

    // All VCs requesting: full round-robin sweep
    repeat (6) step(1'b0, 1'b0, 4'b0000, HEADS, 4'b0000);

    // Single requester VC2 for 3 words, then empty
    repeat (3) step(1'b0, 1'b0, 4'b1011, HEADS, 4'b0000);
    repeat (2) step(1'b0, 1'b0, 4'b1111, HEADS, 4'b0000);

    // Backpressure: stall 4 cycles, resume from the saved pointer
    step(1'b0, 1'b0, 4'b0000, HEADS, 4'b0000);
    repeat (4) step(1'b0, 1'b0, 4'b0000, HEADS, 4'b0010);
    repeat (3) step(1'b0, 1'b0, 4'b0000, HEADS, 4'b0000);

    // Init holds off grants; first pop right after release
    repeat (3) step(1'b0, 1'b1, 4'b0000, HEADS, 4'b0000);
    repeat (2) step(1'b0, 1'b0, 4'b0000, HEADS, 4'b0000);

    // VC0 and VC3 requesting, then reset mid-stream
    repeat (4) step(1'b0, 1'b0, 4'b0110, HEADS, 4'b0000);
    step(1'b1, 1'b0, 4'b0110, HEADS, 4'b0000);
    repeat (2) step(1'b0, 1'b0, 4'b0110, HEADS, 4'b0000);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic       r_rst;
      logic       r_ini;
      logic [3:0] r_emp;
      logic [3:0] r_af;
      logic [23:0] r_din;
      r_rst = ($urandom_range(0, 49) == 0);
      r_ini = ($urandom_range(0, 9) == 0);
      r_emp = 4'($urandom);
      r_af  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'b0000;
      r_din = 24'($urandom);
      step(r_rst, r_ini, r_emp, r_din, r_af);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
